// File: rtl/issue_bru_fifo.sv
// First-word-fall-through queue holding issued branch/jump packets for execute_bru.
// The head packet is presented combinationally; a commit-stage flush empties it in one edge.

package issue_bru_pkg;

  typedef struct packed {
    logic        enable;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  op;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic        predicted_jump;
  } issue_execute_pack_t;

  typedef struct packed {
    logic        enable;
    logic        flush;
    logic [31:0] next_pc;
  } commit_feedback_pack_t;

endpackage

module issue_bru_fifo
  import issue_bru_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  issue_execute_pack_t         issue_bru_fifo_data_in,
  input  logic                        issue_bru_fifo_push,
  output logic                        issue_bru_fifo_full,
  output issue_execute_pack_t         issue_bru_fifo_data_out,
  output logic                        issue_bru_fifo_data_out_valid,
  input  logic                        issue_bru_fifo_pop,
  input  commit_feedback_pack_t       commit_feedback_pack,
  output logic [$clog2(DEPTH):0]      issue_bru_fifo_count
);

  localparam int AW = $clog2(DEPTH);

  issue_execute_pack_t mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  logic flush;
  logic push_ok;
  logic pop_ok;
  logic full;
  logic valid;

  logic unused_fb;
  assign unused_fb = ^commit_feedback_pack.next_pc;

  assign flush   = commit_feedback_pack.enable & commit_feedback_pack.flush;
  assign valid   = (wptr != rptr);
  assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) & (wptr[AW] != rptr[AW]);
  assign push_ok = issue_bru_fifo_push & ~full;
  assign pop_ok  = issue_bru_fifo_pop & valid;

  // Flush wins over everything; otherwise push and pop advance independently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: pointers alone decide what is visible.
  always_ff @(posedge clk) begin
    if (!flush && push_ok) mem[wptr[AW-1:0]] <= issue_bru_fifo_data_in;
  end

  assign issue_bru_fifo_full           = full;
  assign issue_bru_fifo_data_out_valid = valid;
  assign issue_bru_fifo_data_out       = valid ? mem[rptr[AW-1:0]] : '0;
  assign issue_bru_fifo_count          = wptr - rptr;

endmodule
